// File: rtl/proc_pkg.sv
// Shared constants for the 8-bit processor: opcodes, fetch FSM encoding, default widths.
package proc_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 8;

    localparam logic [2:0] OP_R   = 3'b000;
    localparam logic [2:0] OP_MFI = 3'b001;
    localparam logic [2:0] OP_MW  = 3'b010;
    localparam logic [2:0] OP_MR  = 3'b011;
    localparam logic [2:0] OP_J   = 3'b100;
    localparam logic [2:0] OP_JCE = 3'b101;
    localparam logic [2:0] OP_MB  = 3'b110;
    localparam logic [2:0] OP_JCN = 3'b111;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_seq_branch_resolve.sv
// Next-PC selection: jump target when taken, otherwise pc+1 with natural wrap.
module branch_resolve #(
    parameter int PC_W = 8
) (
    input  logic            j,
    input  logic            jc,
    input  logic            neq,
    input  logic            eq,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] jmp_target,
    output logic [PC_W-1:0] next_pc
);

    logic taken;

    // j alone is enough, so it dominates whenever jc is also high
    assign taken   = j | (jc & (eq ^ neq));
    assign next_pc = taken ? jmp_target : pc + {{(PC_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/instr_fetch_seq.sv
// Fetch/sequencing stage: PC, req/ack instruction fetch, IR and branch-driven PC update.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module instr_fetch_seq
    import proc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [2:0]         opcode,
    output logic [INSTR_W-4:0] imm,
    output logic               ir_valid,
    input  logic               exec_stall,
    input  logic               j,
    input  logic               jc,
    input  logic               neq,
    input  logic               eq,
    input  logic [PC_W-1:0]    jmp_target,
`ifdef INSTR_COUNT_EN
    output logic [15:0]        instr_count,
`endif
    output logic [PC_W-1:0]    pc
);

    fetch_state_e       state, state_nxt;
    logic [INSTR_W-1:0] ir;
    logic [PC_W-1:0]    next_pc;
    logic               ir_load;
    logic               pc_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_adv    = 1'b0;
        case (state)
            FETCH, WAIT: begin
                if (imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = EXEC;
                end else begin
                    state_nxt = WAIT;
                end
            end
            EXEC: begin
                if (!exec_stall) begin
                    pc_adv    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Gating with rst keeps req low during reset and drops it immediately on a mid-fetch reset
    assign imem_req  = !rst && (state == FETCH || state == WAIT);
    assign ir_valid  = (state == EXEC);
    assign imem_addr = pc;
    assign opcode    = ir[INSTR_W-1:INSTR_W-3];
    assign imm       = ir[INSTR_W-4:0];

    branch_resolve #(.PC_W(PC_W)) u_branch (
        .j          (j),
        .jc         (jc),
        .neq        (neq),
        .eq         (eq),
        .pc         (pc),
        .jmp_target (jmp_target),
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (ir_load) ir <= imem_rdata;
            if (pc_adv)  pc <= next_pc;
        end
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         count <= 16'd0;
        else if (pc_adv) count <= count + 16'd1;
    end

    assign instr_count = count;
`endif

endmodule
